mux1: RTL and testbench

//   Two-input multiplexer cell for the microwave controller datapath.
//   X is a purely combinational select: S=0 passes A, S=1 passes B.
//   A registered copy (X_q) plus a select-change flag feed synchronous

---
 rtl/mux1_pkg.sv | 7 +
 rtl/mux1.sv | 41 ++++
 tb/tb_mux1.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux1_pkg.sv
// Shared select encodings for callers driving the mux1 select input.
package mux1_pkg;

    localparam logic MUX_SEL_A = 1'b0;
    localparam logic MUX_SEL_B = 1'b1;

endpackage

// File: rtl/mux1.sv
// Two-input mux cell: combinational output plus a registered copy
// and a one-cycle flag marking a change in the captured select.
module mux1
    import mux1_pkg::*;
#(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_q,
    output logic             sel_chg
);

    logic sel_q;

    // Unknown S merges A and B bitwise, so equal inputs still pass through.
    always_comb begin
        X = (S == MUX_SEL_B) ? B : A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            X_q     <= RST_VAL;
            sel_q   <= MUX_SEL_A;
            sel_chg <= 1'b0;
        end else if (en) begin
            X_q     <= (S == MUX_SEL_B) ? B : A;
            sel_q   <= S;
            sel_chg <= (S != sel_q);
        end else begin
            sel_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux1.sv
// Bench for mux1: directed scenarios plus randomized traffic on a
// 1-bit and an 8-bit instance, checked against a behavioural model.
module tb_mux1;

    logic       clk = 1'b0;
    logic       clk_on = 1'b0;

    logic       rst1, s1, en1, a1, b1;
    logic       x1, xq1, chg1;
    logic       rst8, s8, en8;
    logic [7:0] a8, b8, x8, xq8;
    logic       chg8;

    logic       m_xq1, m_sel1, m_chg1;
    logic [7:0] m_xq8;
    logic       m_sel8, m_chg8;

    int errors = 0;
    int checks = 0;

    always #5 clk = clk_on ? ~clk : clk;

    mux1 #(.WIDTH(1), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .S(s1), .en(en1),
        .X(x1), .X_q(xq1), .sel_chg(chg1)
    );

    mux1 #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
        .clk(clk), .rst(rst8), .A(a8), .B(b8), .S(s8), .en(en8),
        .X(x8), .X_q(xq8), .sel_chg(chg8)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check comb outputs, advance the model, check registers.
    task automatic tick();
        #1;
        check("x1", 32'(x1), 32'((a1 & ~s1) | (b1 & s1)));
        check("x8", 32'(x8), 32'((a8 & ~{8{s8}}) | (b8 & {8{s8}})));
        if (rst1) begin
            m_xq1 = 1'b0; m_sel1 = 1'b0; m_chg1 = 1'b0;
        end else if (en1) begin
            m_chg1 = (s1 != m_sel1);
            m_xq1  = s1 ? b1 : a1;
            m_sel1 = s1;
        end else begin
            m_chg1 = 1'b0;
        end
        if (rst8) begin
            m_xq8 = 8'hA5; m_sel8 = 1'b0; m_chg8 = 1'b0;
        end else if (en8) begin
            m_chg8 = (s8 != m_sel8);
            m_xq8  = s8 ? b8 : a8;
            m_sel8 = s8;
        end else begin
            m_chg8 = 1'b0;
        end
        @(posedge clk);
        #1;
        check("xq1", 32'(xq1), 32'(m_xq1));
        check("chg1", 32'(chg1), 32'(m_chg1));
        check("xq8", 32'(xq8), 32'(m_xq8));
        check("chg8", 32'(chg8), 32'(m_chg8));
    endtask

    initial begin
        logic tt [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] idx;

        rst1 = 1'b0; en1 = 1'b0; s1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        rst8 = 1'b1; en8 = 1'b0; s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;

        // Comb sweep with the clock stopped, index is {S,A,B}.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {s1, a1, b1} = idx;
            #1;
            check("tt", 32'(x1), 32'(tt[i]));
        end

        clk_on = 1'b1;

        // Reset with all inputs high: X stays combinational.
        rst1 = 1'b1; en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; s1 = 1'b1;
        tick();
        check("rst_xq", 32'(xq1), 32'd0);
        check("rst_chg", 32'(chg1), 32'd0);
        check("rst_x", 32'(x1), 32'd1);

        // Register path and one-cycle select-change pulse.
        rst1 = 1'b0; en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
        tick();
        check("reg_a", 32'(xq1), 32'd1);
        check("reg_nochg", 32'(chg1), 32'd0);
        s1 = 1'b1;
        tick();
        check("reg_b", 32'(xq1), 32'd0);
        check("chg_pulse", 32'(chg1), 32'd1);
        tick();
        check("chg_drop", 32'(chg1), 32'd0);

        // Enable low: inputs wiggle, registers hold.
        en1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = ~a1; b1 = ~b1; s1 = ~s1;
            tick();
            check("hold_xq", 32'(xq1), 32'd0);
            check("hold_chg", 32'(chg1), 32'd0);
        end
        // Held select is still 1, so re-enabling with S=1 gives no pulse.
        en1 = 1'b1; s1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("hold_sel", 32'(chg1), 32'd0);
        check("hold_rel", 32'(xq1), 32'd1);

        // Wide instance: reset value, then pass-through of B.
        rst8 = 1'b1;
        tick();
        check("w8_rst", 32'(xq8), 32'hA5);
        rst8 = 1'b0; en8 = 1'b1; a8 = 8'h3C; b8 = 8'hC3; s8 = 1'b1;
        #1;
        check("w8_x", 32'(x8), 32'hC3);
        tick();
        check("w8_xq", 32'(xq8), 32'hC3);
        check("w8_chg", 32'(chg8), 32'd1);

        // Reset mid-run, then select compares against cleared sel_q.
        rst8 = 1'b1;
        tick();
        check("mid_xq", 32'(xq8), 32'hA5);
        check("mid_chg", 32'(chg8), 32'd0);
        rst8 = 1'b0;
        tick();
        check("mid_first", 32'(chg8), 32'd1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            rst1 = ($urandom_range(15) == 0);
            rst8 = ($urandom_range(15) == 0);
            en1  = 1'($urandom);
            en8  = 1'($urandom);
            s1   = 1'($urandom);
            s8   = 1'($urandom);
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
